// File: rtl/imem_loader_ctrl_pkg.sv
// imem_loader_ctrl_pkg: shared geometry, nop encoding and loader state type
package imem_loader_ctrl_pkg;
   localparam int IMEM_ADDR_W = 6;
   localparam int IMEM_DATA_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000000;
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} ld_state_e;
endpackage

// File: rtl/imem_loader_ctrl_instr_ram.sv
// instr_ram: instruction storage with synchronous write and asynchronous read, no reset
module instr_ram #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   // contents survive reset so an interrupted load leaves untouched words intact
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: shares the instruction RAM between CPU fetch and a byte-wide program loader (optional IMEM_LOADER_CHECKSUM_EN)
module imem_loader_ctrl
   import imem_loader_ctrl_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DATA_W = IMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_stall,
   input  logic              ld_start,
   input  logic [ADDR_W:0]   ld_count,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   output logic              ld_busy,
   output logic              ld_done,
   output logic              ld_err
);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam ld_state_e AFTER_LAST = CHECK;
`else
   localparam ld_state_e AFTER_LAST = DONE;
`endif
   ld_state_e         state, state_n;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W:0]   words_left, count_clamp;
   logic [1:0]        byte_cnt;
   logic [DATA_W-1:0] word_buf, ram_rdata;
   logic              start, accept, last_byte;
   assign count_clamp = (ld_count > DEPTH) ? DEPTH : ld_count;
   assign start       = (state == IDLE) && ld_start;
   assign accept      = ld_valid && ld_ready;
   assign last_byte   = accept && (byte_cnt == 2'd3);
   assign ld_busy     = (state != IDLE);
   assign cpu_stall   = ld_busy;
   assign ld_ready    = (state == RECV) || (state == CHECK);
   assign ld_done     = (state == DONE);
   assign cpu_instr   = ld_busy ? NOP_INSTR[DATA_W-1:0] : ram_rdata;
   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   // next-state: words arrive as 4 bytes then one write cycle; an empty load finishes at once
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (ld_start) state_n = (count_clamp == '0) ? DONE : RECV;
         RECV:    if (last_byte) state_n = WRITE;
         WRITE:   state_n = (words_left > (ADDR_W+1)'(1)) ? RECV : AFTER_LAST;
         CHECK:   if (last_byte) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // byte assembly (big-endian) and write-address bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_addr    <= '0;
         words_left <= '0;
         byte_cnt   <= '0;
         word_buf   <= '0;
      end else if (start) begin
         wr_addr    <= '0;
         words_left <= count_clamp;
         byte_cnt   <= '0;
         word_buf   <= '0;
      end else begin
         if (accept) begin
            word_buf <= {word_buf[DATA_W-9:0], ld_data};
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == WRITE) begin
            wr_addr    <= wr_addr + 1'b1;
            words_left <= words_left - 1'b1;
         end
      end
   end
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
   logic              err_q;
   // running XOR of written words; the trailing word left in word_buf is the sender's checksum
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csum  <= '0;
         err_q <= 1'b0;
      end else if (start) begin
         csum  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == WRITE) csum <= csum ^ word_buf;
         if (state == DONE) err_q <= (word_buf != csum);
      end
   end
   assign ld_err = err_q;
`else
   assign ld_err = 1'b0;
`endif
   instr_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .we    (state == WRITE),
      .waddr (wr_addr),
      .wdata (word_buf),
      .raddr (cpu_addr),
      .rdata (ram_rdata)
   );
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: randomized loads against a word-level memory model with a queue-based scoreboard
module tb_imem_loader_ctrl;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif
   typedef struct {int lat; logic err;} done_t;
   logic        clk = 1'b0, reset = 1'b1;
   logic [5:0]  cpu_addr = '0;
   logic [31:0] cpu_instr;
   logic        cpu_stall, ld_start = 1'b0, ld_valid = 1'b0, ld_ready, ld_busy, ld_done, ld_err;
   logic [6:0]  ld_count = '0;
   logic [7:0]  ld_data = '0;
   int          vec = 0, mis = 0, cyc = 0;
   logic [31:0] model [64];
   logic [31:0] wl [64];
   done_t       done_q [$];
   logic [31:0] rd_q [$];
   int          arm_id = 0, start_cyc = 0, m_total = 0, m_data = 0, tmo = 0;
   bit          rd_req = 1'b0, fin = 1'b0;
   int          done_id = 0, m_acc = 0, stall_cnt = 0, lat = 0;
   bit          m_wjd = 1'b0, post_done = 1'b0, exp_err = 1'b0, exp_rdy, acc;
   done_t       e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_loader_ctrl dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
      .ld_start(ld_start), .ld_count(ld_count), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: per-cycle protocol rules plus queue pops on ld_done and read strobes
   always @(negedge clk) begin
      if (reset) begin
         chk("reset ld_busy", 32'(ld_busy), 0);
         chk("reset cpu_stall", 32'(cpu_stall), 0);
         chk("reset ld_ready", 32'(ld_ready), 0);
         chk("reset ld_done", 32'(ld_done), 0);
         chk("reset ld_err", 32'(ld_err), 0);
         done_id = arm_id;
         post_done = 1'b0;
         exp_err = 1'b0;
      end else begin
         if (post_done) begin
            chk("stall after done", 32'(cpu_stall), 0);
            chk("ld_err after done", 32'(ld_err), 32'(exp_err));
            post_done = 1'b0;
         end else if (arm_id == done_id) chk("ld_err idle", 32'(ld_err), 32'(exp_err));
         if (arm_id != done_id && cyc == start_cyc) begin
            m_acc = 0;
            m_wjd = 1'b0;
            stall_cnt = 0;
         end else if (arm_id != done_id) begin
            exp_rdy = (m_acc < m_total) && !m_wjd;
            chk("ld_ready", 32'(ld_ready), 32'(exp_rdy));
            chk("nop while stalled", cpu_instr, 32'h0);
            if (cpu_stall) stall_cnt++;
            acc = ld_valid && ld_ready;
            m_wjd = acc && (m_acc % 4 == 3) && (m_acc < m_data);
            if (acc) m_acc++;
            if (ld_done) begin
               lat = cyc - start_cyc;
               if (done_q.size() == 0) begin
                  vec++;
                  mis++;
                  $display("FAIL done without pending load: got ld_done=1 expected 0");
               end else begin
                  e = done_q.pop_front();
                  if (e.lat >= 0) chk("done latency", 32'(lat), 32'(e.lat));
                  chk("stall cycles", 32'(stall_cnt), 32'(lat));
                  exp_err = e.err;
               end
               post_done = 1'b1;
               done_id = arm_id;
            end
         end else if (ld_done) chk("spurious ld_done", 32'(ld_done), 0);
         if (rd_req && rd_q.size() > 0) chk($sformatf("read addr %0d", cpu_addr), cpu_instr, rd_q.pop_front());
      end
      if (fin) begin
         chk("timeouts", 32'(tmo), 0);
         chk("undrained expectations", 32'(done_q.size() + rd_q.size()), 0);
         $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
         $finish;
      end
   end

   task automatic rd(input int a);
      @(posedge clk); #1;
      cpu_addr = 6'(a);
      rd_q.push_back(model[a]);
      rd_req = 1'b1;
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   // gaps: 0 valid held high, 1 toggling, 2 random; abort_at>0 resets mid-load after two words
   task automatic do_load(input int n_req, input int gaps, input bit bad_cs, input bit extra, input bit at_done, input int abort_at);
      int n, total, idx, g;
      bit sent, ok;
      logic [31:0] cs, cw;
      logic [7:0] bytes [$];
      n = (n_req > 64) ? 64 : n_req;
      cs = '0;
      for (int i = 0; i < n; i++) begin
         cs ^= wl[i];
         for (int b = 3; b >= 0; b--) bytes.push_back(wl[i][8*b +: 8]);
      end
      if (CS && n > 0) begin
         cw = bad_cs ? 32'h0 : cs;
         for (int b = 3; b >= 0; b--) bytes.push_back(cw[8*b +: 8]);
      end
      total = bytes.size();
      for (int i = 0; i < ((abort_at > 0) ? 2 : n); i++) model[i] = wl[i];
      if (abort_at == 0)
         done_q.push_back('{lat: (gaps != 0) ? -1 : ((n == 0) ? 1 : 5*n + 1 + (CS ? 4 : 0)), err: CS && bad_cs && n > 0});
      @(posedge clk); #1;
      m_total = total;
      m_data = 4*n;
      start_cyc = cyc;
      arm_id++;
      ld_start = 1'b1;
      ld_count = 7'(n_req);
      idx = 0;
      g = 0;
      while (idx < total && g < 4000) begin
         @(posedge clk); #1;
         g++;
         ld_start = extra && g == 20;
         if (abort_at > 0 && g == abort_at) begin
            reset = 1'b1;
            ld_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            return;
         end
         ld_valid = (gaps == 0) ? 1'b1 : (gaps == 1) ? g[0] : 1'($urandom_range(0, 1));
         ld_data = bytes[idx];
         if (ld_valid && ld_ready) idx++;
      end
      if (idx < total) begin
         tmo++;
         $display("FAIL byte stream stalled: accepted %0d expected %0d", idx, total);
      end
      sent = 1'b0;
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
         @(posedge clk); #1;
         ld_valid = 1'b0;
         ld_start = at_done && ld_done && !sent;
         if (ld_start) begin
            sent = 1'b1;
            ld_count = 7'd5;
         end
         ok = !ld_busy;
      end
      ld_start = 1'b0;
      if (!ok) begin
         tmo++;
         $display("FAIL load never finished: ld_busy=1 expected 0");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 64; i++) wl[i] = $urandom;
      do_load(100, 0, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 64; i++) rd(i);
      wl[0] = 32'h20020005; wl[1] = 32'h2003000c; wl[2] = 32'h2067fff7;
      do_load(3, 0, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) rd(i);
      rd(63);
      do_load(3, 1, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) rd(i);
      repeat (4) begin
         int n;
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) wl[i] = $urandom;
         do_load(n, 2, 1'b0, 1'b0, 1'b1, 0);
         for (int i = 0; i <= n; i++) rd(i);
      end
      do_load(0, 0, 1'b0, 1'b0, 1'b1, 0);
      for (int i = 0; i < 4; i++) rd(i);
      for (int i = 0; i < 4; i++) wl[i] = $urandom;
      do_load(4, 0, 1'b0, 1'b0, 1'b0, 13);
      for (int i = 0; i < 4; i++) rd(i);
      if (CS) begin
         wl[0] = 32'h20020005; wl[1] = 32'h2003000c;
         do_load(2, 0, 1'b0, 1'b0, 1'b0, 0);
         do_load(2, 2, 1'b1, 1'b0, 1'b0, 0);
         for (int i = 0; i < 2; i++) rd(i);
         do_load(0, 0, 1'b0, 1'b0, 1'b0, 0);
      end
      @(posedge clk); #1;
      fin = 1'b1;
   end
endmodule
